instr_fetch: RTL and testbench

//  Fetch stage of the 8-bit CPU. Holds the PC, fetches one 8-bit instruction
//  at a time from instruction memory (req/ack), registers it, and hands it to

---
 rtl/instr_fetch.sv | 91 +++++++++
 tb/tb_instr_fetch.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: PC holder and single-outstanding instruction fetch with decode handshake, redirect/squash and halt
module instr_fetch #(
  parameter int PC_W = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            Clk,
  input  logic            Clear_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [7:0]      instr,
  output logic [1:0]      op,
  output logic [1:0]      rs,
  output logic [1:0]      rt,
  output logic [1:0]      imm,
  output logic [PC_W-1:0] pc_out,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t state, state_n;
  logic [PC_W-1:0] pc, pc_n, old_pc, old_pc_n, pc_out_n;
  logic squash, squash_n, valid_n;
  logic [7:0] instr_n;
  always_ff @(posedge Clk or negedge Clear_n)
    if (!Clear_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      old_pc <= RESET_PC;
      squash <= 1'b0;
      instr_valid <= 1'b0;
      instr <= '0;
      pc_out <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      old_pc <= old_pc_n;
      squash <= squash_n;
      instr_valid <= valid_n;
      instr <= instr_n;
      pc_out <= pc_out_n;
    end
  // A redirect during an unacknowledged fetch keeps the request at its old address until the memory answers
  always_comb begin
    state_n = state;
    pc_n = pc;
    old_pc_n = old_pc;
    squash_n = squash;
    valid_n = instr_valid;
    instr_n = instr;
    pc_out_n = pc_out;
    if (redirect) begin
      pc_n = redirect_pc;
      valid_n = 1'b0;
      if (state == FETCH) begin
        squash_n = !imem_ack;
        if (!imem_ack && !squash) old_pc_n = pc;
      end else state_n = halt ? IDLE : FETCH;
    end else
      case (state)
        IDLE: state_n = halt ? IDLE : FETCH;
        FETCH:
          if (imem_ack) begin
            if (squash) squash_n = 1'b0;
            else begin
              instr_n = imem_rdata;
              pc_out_n = pc;
              pc_n = pc + 1'b1;
              valid_n = 1'b1;
              state_n = HOLD;
            end
          end
        HOLD:
          if (instr_valid && instr_ready) begin
            valid_n = 1'b0;
            state_n = halt ? IDLE : FETCH;
          end
        default: state_n = IDLE;
      endcase
  end
  assign imem_req = state == FETCH;
  assign imem_addr = squash ? old_pc : pc;
  assign op = instr[7:6];
  assign rs = instr[5:4];
  assign rt = instr[3:2];
  assign imm = instr[1:0];
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: decode table, directed corner sequences and randomized run against a transaction-level model
module tb_instr_fetch;
  logic Clk = 0, Clear_n = 0;
  logic imem_req, imem_ack = 0, instr_valid, instr_ready = 0, redirect = 0, halt = 0;
  logic [7:0] imem_addr, imem_rdata = 0, instr, pc_out, redirect_pc = 0;
  logic [1:0] op, rs, rt, imm;
  int checks = 0, errors = 0;
  logic [7:0] mem [256];

  instr_fetch dut (
    .Clk(Clk), .Clear_n(Clear_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .op(op), .rs(rs), .rt(rt), .imm(imm),
    .pc_out(pc_out), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
  );

  always #5 Clk = ~Clk;

  // model: next pc, whether a fetch is outstanding, whether its data must be dropped, held instruction
  int m_pc, m_old, m_instr, m_pcout;
  bit m_busy, m_drop, m_have;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_old = 0; m_instr = 0; m_pcout = 0;
    m_busy = 0; m_drop = 0; m_have = 0;
  endtask

  task automatic check_all();
    chk("req", int'(imem_req), int'(m_busy));
    chk("addr", int'(imem_addr), m_drop ? m_old : m_pc);
    chk("valid", int'(instr_valid), int'(m_have));
    chk("instr", int'(instr), m_instr);
    chk("op", int'(op), m_instr / 64);
    chk("rs", int'(rs), (m_instr / 16) % 4);
    chk("rt", int'(rt), (m_instr / 4) % 4);
    chk("imm", int'(imm), m_instr % 4);
    chk("pc_out", int'(pc_out), m_pcout);
  endtask

  task automatic model_step(input bit red, input int rpc, input bit hlt, input bit ack, input bit rdy, input int data);
    if (red) begin
      if (m_busy) begin
        if (ack) m_drop = 0;
        else if (!m_drop) begin m_drop = 1; m_old = m_pc; end
      end else m_busy = !hlt;
      m_pc = rpc;
      m_have = 0;
    end else if (m_busy) begin
      if (ack && m_drop) m_drop = 0;
      else if (ack) begin
        m_have = 1; m_instr = data; m_pcout = m_pc;
        m_pc = (m_pc + 1) % 256; m_busy = 0;
      end
    end else if (m_have) begin
      if (rdy) begin m_have = 0; m_busy = !hlt; end
    end else m_busy = !hlt;
  endtask

  // drive one cycle of inputs, advance model, then check outputs after the edge
  task automatic step(input bit red, input logic [7:0] rpc, input bit hlt, input bit ack, input bit rdy);
    redirect = red; redirect_pc = rpc; halt = hlt; instr_ready = rdy;
    imem_ack = ack & imem_req;
    imem_rdata = mem[imem_addr];
    model_step(red, int'(rpc), hlt, imem_ack, rdy, int'(imem_rdata));
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    Clear_n = 0; redirect = 0; halt = 0; imem_ack = 0; instr_ready = 0;
    #1;
    model_reset();
    check_all();
    @(negedge Clk);
    Clear_n = 1;
  endtask

  typedef struct {logic [7:0] rdata; logic [1:0] op, rs, rt, imm;} vec_t;
  vec_t tbl [6];

  initial begin
    tbl[0] = '{8'hB6, 2'd2, 2'd3, 2'd1, 2'd2};
    tbl[1] = '{8'h00, 2'd0, 2'd0, 2'd0, 2'd0};
    tbl[2] = '{8'hFF, 2'd3, 2'd3, 2'd3, 2'd3};
    tbl[3] = '{8'h1B, 2'd0, 2'd1, 2'd2, 2'd3};
    tbl[4] = '{8'hE4, 2'd3, 2'd2, 2'd1, 2'd0};
    tbl[5] = '{8'h5A, 2'd1, 2'd1, 2'd2, 2'd2};
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      mem[0] = tbl[i].rdata;
      do_reset();
      step(0, 0, 0, 0, 0);
      chk("t1_req", int'(imem_req), 1);
      chk("t1_addr", int'(imem_addr), 0);
      step(0, 0, 0, 1, 0);
      chk("t1_valid", int'(instr_valid), 1);
      chk("t1_op", int'(op), int'(tbl[i].op));
      chk("t1_rs", int'(rs), int'(tbl[i].rs));
      chk("t1_rt", int'(rt), int'(tbl[i].rt));
      chk("t1_imm", int'(imm), int'(tbl[i].imm));
      chk("t1_pc_out", int'(pc_out), 0);
      chk("t1_next_addr", int'(imem_addr), 1);
    end
    // hold with ready low, then handoff to the next fetch
    mem[0] = 8'hB6;
    do_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0);
      chk("t2_instr", int'(instr), 8'hB6);
      chk("t2_noreq", int'(imem_req), 0);
    end
    step(0, 0, 0, 0, 1);
    chk("t2_valid", int'(instr_valid), 0);
    chk("t2_req", int'(imem_req), 1);
    chk("t2_addr", int'(imem_addr), 1);
    // redirect while waiting for ack
    step(1, 8'h40, 0, 0, 0);
    chk("t3_addr_hold", int'(imem_addr), 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t3_addr_hold2", int'(imem_addr), 1);
    step(0, 0, 0, 1, 0);
    chk("t3_no_valid", int'(instr_valid), 0);
    chk("t3_addr_new", int'(imem_addr), 8'h40);
    chk("t3_req", int'(imem_req), 1);
    // redirect coincident with ack
    step(1, 8'h10, 0, 1, 0);
    chk("t4_no_valid", int'(instr_valid), 0);
    chk("t4_addr", int'(imem_addr), 8'h10);
    step(0, 0, 0, 1, 0);
    chk("t4_valid", int'(instr_valid), 1);
    chk("t4_pc_out", int'(pc_out), 8'h10);
    // wrap at 0xFF and halt at handoff
    step(1, 8'hFF, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("t5_pc_out", int'(pc_out), 8'hFF);
    chk("t5_wrap", int'(imem_addr), 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 1);
      chk("t5_halted", int'(imem_req), 0);
    end
    step(0, 0, 0, 0, 0);
    chk("t5_resume", int'(imem_req), 1);
    chk("t5_resume_addr", int'(imem_addr), 0);
    // asynchronous reset between edges during HOLD
    step(0, 0, 0, 1, 0);
    #3 Clear_n = 0;
    #1;
    model_reset();
    chk("t6_valid", int'(instr_valid), 0);
    chk("t6_req", int'(imem_req), 0);
    chk("t6_instr", int'(instr), 0);
    #1 Clear_n = 1;
    step(0, 0, 0, 0, 0);
    chk("t6_restart", int'(imem_req), 1);
    step(0, 0, 0, 1, 0);
    chk("t6_pc_out", int'(pc_out), 0);
    // asynchronous reset between edges during FETCH
    step(0, 0, 0, 0, 1);
    #3 Clear_n = 0;
    #1;
    model_reset();
    chk("t6_req_f", int'(imem_req), 0);
    #1 Clear_n = 1;
    // randomized run
    for (int i = 0; i < 600; i++)
      step($urandom_range(9) == 0, 8'($urandom), $urandom_range(4) == 0,
           1'($urandom), 1'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
